// File: rtl/ysyx_040750_lsu_ctrl.sv
// MEM-stage load/store controller: one aligned 64-bit memory access per
// request, with lane-shifted store data/strobes and aligned, extended loads.
module ysyx_040750_lsu_ctrl (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic        I_req_wen,
  input  logic [63:0] I_req_addr,
  input  logic [1:0]  I_req_size,
  input  logic        I_req_sext,
  input  logic [63:0] I_req_wdata,
  output logic        O_resp_valid,
  input  logic        I_resp_ready,
  output logic [63:0] O_resp_rdata,
  output logic        O_resp_err,
  output logic        O_resp_misalign,
  output logic        O_mem_req,
  input  logic        I_mem_gnt,
  output logic        O_mem_we,
  output logic [63:0] O_mem_addr,
  output logic [63:0] O_mem_wdata,
  output logic [7:0]  O_mem_wstrb,
  input  logic        I_mem_rvalid,
  input  logic [63:0] I_mem_rdata,
  input  logic        I_mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic        wen_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [2:0]  shamt_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [7:0]  wstrb_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        misalign_q;

  // Byte mask covering an access of the given size, before lane shifting.
  function automatic logic [7:0] base_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Natural-alignment check: the low address bits inside the access size must be 0.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

  // Move the addressed lanes down to bit 0, mask to size, optionally sign-extend.
  function automatic logic [63:0] fmt_load(input logic [63:0] raw, input logic [2:0] sh,
                                           input logic [1:0] sz, input logic sx);
    logic [63:0] d;
    logic [63:0] m;
    logic [7:0]  bm;
    logic        sb;
    d  = raw >> {sh, 3'b000};
    bm = base_mask(sz);
    m  = '0;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{bm[i]}};
    end
    case (sz)
      2'd0:    sb = d[7];
      2'd1:    sb = d[15];
      2'd2:    sb = d[31];
      default: sb = 1'b0;
    endcase
    if (sx && sb) begin
      return (d & m) | ~m;
    end
    return d & m;
  endfunction

  // Transaction FSM; request fields are latched and pre-shifted at accept time
  // so every memory-side output is a plain register during REQ.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state       <= IDLE;
      wen_q       <= 1'b0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      shamt_q     <= 3'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_req_valid) begin
            wen_q       <= I_req_wen;
            size_q      <= I_req_size;
            sext_q      <= I_req_sext;
            shamt_q     <= I_req_addr[2:0];
            mem_addr_q  <= {I_req_addr[63:3], 3'b000};
            mem_wdata_q <= I_req_wdata << {I_req_addr[2:0], 3'b000};
            wstrb_q     <= I_req_wen ? (base_mask(I_req_size) << I_req_addr[2:0]) : 8'h00;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            misalign_q  <= is_misaligned(I_req_size, I_req_addr[2:0]);
            state       <= is_misaligned(I_req_size, I_req_addr[2:0]) ? RESP : REQ;
          end
        end
        REQ: begin
          if (I_mem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (I_mem_rvalid) begin
            err_q   <= I_mem_err;
            rdata_q <= (I_mem_err || wen_q) ? 64'd0
                                            : fmt_load(I_mem_rdata, shamt_q, size_q, sext_q);
            state   <= RESP;
          end
        end
        default: begin
          if (I_resp_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Handshake and memory-request outputs decoded from state and registers only.
  always_comb begin
    O_req_ready     = (state == IDLE);
    O_resp_valid    = (state == RESP);
    O_resp_rdata    = rdata_q;
    O_resp_err      = err_q;
    O_resp_misalign = misalign_q;
    O_mem_req       = (state == REQ);
    O_mem_we        = (state == REQ) && wen_q;
    O_mem_addr      = mem_addr_q;
    O_mem_wdata     = mem_wdata_q;
    O_mem_wstrb     = (state == REQ) ? wstrb_q : 8'h00;
  end

endmodule

// File: doc/ysyx_040750_lsu_ctrl.md
# ysyx_040750_lsu_ctrl

Load/store unit controller for the MEM stage of the full-pipeline core. It accepts one memory operation at a time from the pipeline, issues a single aligned 64-bit access on the data-memory request/response port, and returns the load result with byte-lane selection, shifting and sign-extension applied (same 9-bit strobe semantics as the load aligner: bits [7:0] byte mask, bit 8 sign-extend). It also flags misaligned accesses without touching memory.

## Interface
- No parameters; data width fixed at 64, address width fixed at 64.
- I_sys_clk  input  1  clock; all state updates on rising edge
- I_rst  input  1  synchronous, active-high reset
- I_req_valid  input  1  pipeline request valid
- O_req_ready  output  1  controller can accept a request
- I_req_wen  input  1  1 = store, 0 = load
- I_req_addr  input  64  byte address
- I_req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double
- I_req_sext  input  1  sign-extend load result (ignored for stores and size 3)
- I_req_wdata  input  64  store data, right-justified
- O_resp_valid  output  1  response valid
- I_resp_ready  input  1  pipeline accepts response
- O_resp_rdata  output  64  aligned, extended load data; 0 for stores and errors
- O_resp_err  output  1  bus error reported by memory
- O_resp_misalign  output  1  address not naturally aligned to size
- O_mem_req  output  1  memory request valid
- I_mem_gnt  input  1  memory accepts request this cycle
- O_mem_we  output  1  write request
- O_mem_addr  output  64  request address, bits [2:0] forced to 0
- O_mem_wdata  output  64  lane-shifted store data
- O_mem_wstrb  output  8  byte write enables
- I_mem_rvalid  input  1  response (read data or write ack) valid, one-cycle pulse
- I_mem_rdata  input  64  read data, full aligned doubleword
- I_mem_err  input  1  error qualifier for I_mem_rvalid

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: O_req_ready = 1. On I_req_valid: latch wen, addr, size, sext, wdata. Misaligned (half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0) -> RESP with misalign = 1, no memory access. Otherwise -> REQ.
- Base mask: size 0/1/2/3 -> 8'h01/8'h03/8'h0f/8'hff. Shamt = addr[2:0].
- REQ: O_mem_req = 1; O_mem_addr = {addr[63:3],3'b0}; O_mem_we = wen; O_mem_wstrb = wen ? base << shamt : 8'h00; O_mem_wdata = wdata << (shamt·8). All held stable until I_mem_gnt, then -> WAIT.
- WAIT: on I_mem_rvalid -> RESP. Load data: d = I_mem_rdata >> (shamt·8); result = d & byte-expanded base; if sext and size < 3, bytes outside base filled with sign bit d[7]/d[15]/d[31]. If I_mem_err: rdata = 0, err = 1. Stores: rdata = 0.
- RESP: O_resp_valid = 1, outputs registered and stable until I_resp_ready, then -> IDLE.
- Response flags are mutually exclusive; err and misalign never both 1.
- I_mem_rvalid outside WAIT is ignored. I_mem_gnt outside REQ is ignored.

## Timing
- Reset (I_rst sampled high at edge): state IDLE; O_req_ready = 1 after reset deasserts; O_resp_valid, O_mem_req, O_mem_we, O_resp_err, O_resp_misalign = 0; O_mem_wstrb = 0; O_resp_rdata, O_mem_addr, O_mem_wdata = 0.
- Reset mid-operation (any state) aborts the transaction; memory side is reset from the same I_rst and produces no late response.
- All outputs are registered/decoded from state; no combinational path from I_mem_* or I_req_* to any output.
- Minimum load/store latency: accept edge 0, O_mem_req high cycle 1, I_mem_gnt cycle 1, I_mem_rvalid cycle 2, O_resp_valid cycle 3.
- Misaligned: accept edge 0, O_resp_valid cycle 1.
- One transaction in flight; O_req_ready low from accept until the cycle after the response handshake.
- I_mem_gnt and I_mem_rvalid in the same cycle in REQ: rvalid is ignored (memory guarantees rvalid at least one cycle after gnt).

## Test plan
- Load byte sext: addr 0x8000_0005, size 0, sext 1, I_mem_rdata 0x0011_8000_0000_0000 -> O_mem_addr 0x8000_0000, O_resp_rdata 0xFFFF_FFFF_FFFF_FF80.
- Load word zero-ext: addr 0x8000_0004, size 2, sext 0, rdata 0x8765_4321_0000_0000 -> rdata 0x0000_0000_8765_4321, latency 3 cycles with immediate gnt.
- Store half: addr 0x8000_0006, size 1, wdata 0xBEEF -> O_mem_wstrb 8'hC0, O_mem_wdata 0xBEEF_0000_0000_0000, O_mem_we 1; held 4 cycles with gnt low, single response after ack.
- Misaligned word at addr 0x8000_0002 -> no O_mem_req pulse, O_resp_misalign 1 at cycle 1.
- Bus error: load double, I_mem_err 1 with rvalid -> O_resp_err 1, rdata 0; I_resp_ready low 3 cycles -> response held stable.
- Reset asserted in WAIT -> next cycle all outputs at reset values, late-free; subsequent load completes normally.
